// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: operand/opcode bus between the sequencer (master) and the ALU (slave).
interface alu_operand_sequencer_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [WIDTH-1:0] ALUResult;
   logic [2:0] ALUControl;
   logic Zero;
   modport master (output SrcA, SrcB, ALUControl, input ALUResult, Zero);
   modport slave (input SrcA, SrcB, ALUControl, output ALUResult, Zero);
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced key steps capture of A, B, opcode, then registers the ALU result.
// ALU_SEQ_KEEP_OPERANDS_EN: a press in SHOW returns to LOAD_OP so SrcA/SrcB are reused.
module alu_operand_sequencer #(
   parameter int WIDTH = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input logic clk,
   input logic rst_n,
   input logic key_n,
   input logic [WIDTH-1:0] sw,
   input logic [2:0] op_sw,
   alu_operand_sequencer_if.master alu,
   output logic [WIDTH-1:0] result_q,
   output logic zero_q,
   output logic [2:0] state,
   output logic done
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   typedef enum logic [2:0] {LOAD_A = 3'd0, LOAD_B = 3'd1, LOAD_OP = 3'd2, EXEC = 3'd3, SHOW = 3'd4} state_t;
`ifdef ALU_SEQ_KEEP_OPERANDS_EN
   localparam state_t AFTER_SHOW = LOAD_OP;
`else
   localparam state_t AFTER_SHOW = LOAD_A;
`endif
   logic [1:0] sync;
   logic level;
   logic flip;
   logic press;
   logic [CW-1:0] cnt;
   state_t cur;
   state_t nxt;
   logic ld_a;
   logic ld_b;
   logic ld_op;
   logic cap;
   assign flip = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   assign done = state == SHOW;
   // press fires only on the accepted 1->0 transition, so a held key gives one pulse
   always_ff @(posedge clk)
      if (!rst_n) begin
         sync <= 2'b11;
         level <= 1'b1;
         cnt <= '0;
         press <= 1'b0;
      end else begin
         sync <= {sync[0], key_n};
         cnt <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
         level <= level ^ flip;
         press <= flip & level;
      end
   always_comb begin
      cur = state_t'(state);
      nxt = LOAD_A;
      ld_a = 1'b0;
      ld_b = 1'b0;
      ld_op = 1'b0;
      cap = 1'b0;
      case (cur)
         LOAD_A: begin
            nxt = press ? LOAD_B : LOAD_A;
            ld_a = press;
         end
         LOAD_B: begin
            nxt = press ? LOAD_OP : LOAD_B;
            ld_b = press;
         end
         LOAD_OP: begin
            nxt = press ? EXEC : LOAD_OP;
            ld_op = press;
         end
         EXEC: begin
            nxt = SHOW;
            cap = 1'b1;
         end
         SHOW: nxt = press ? AFTER_SHOW : SHOW;
         default: nxt = LOAD_A;
      endcase
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= LOAD_A;
         alu.SrcA <= '0;
         alu.SrcB <= '0;
         alu.ALUControl <= '0;
         result_q <= '0;
         zero_q <= 1'b0;
      end else begin
         state <= nxt;
         if (ld_a) alu.SrcA <= sw;
         if (ld_b) alu.SrcB <= sw;
         if (ld_op) alu.ALUControl <= op_sw;
         if (cap) begin
            result_q <= alu.ALUResult;
            zero_q <= alu.Zero;
         end
      end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed and random key presses against a transaction-level model.
module tb_alu_operand_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   logic key_n;
   logic [3:0] sw;
   logic [2:0] op_sw;
   logic [3:0] result_q;
   logic zero_q;
   logic [2:0] state;
   logic done;
   int checks = 0;
   int errors = 0;
   logic [2:0] m_state;
   logic [3:0] m_a, m_b, m_res;
   logic [2:0] m_op;
   logic m_z;
`ifdef ALU_SEQ_KEEP_OPERANDS_EN
   localparam logic [2:0] SHOW_NEXT = 3'd2;
`else
   localparam logic [2:0] SHOW_NEXT = 3'd0;
`endif

   alu_operand_sequencer_if #(.WIDTH(4)) bus ();

   alu_operand_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_n(key_n),
      .sw(sw),
      .op_sw(op_sw),
      .alu(bus.master),
      .result_q(result_q),
      .zero_q(zero_q),
      .state(state),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"}, 32'(state), 32'(m_state));
      check({tag, ".done"}, 32'(done), 32'(m_state == 3'd4));
      check({tag, ".SrcA"}, 32'(bus.SrcA), 32'(m_a));
      check({tag, ".SrcB"}, 32'(bus.SrcB), 32'(m_b));
      check({tag, ".ALUControl"}, 32'(bus.ALUControl), 32'(m_op));
      check({tag, ".result_q"}, 32'(result_q), 32'(m_res));
      check({tag, ".zero_q"}, 32'(zero_q), 32'(m_z));
   endtask

   task automatic model_reset();
      m_state = 3'd0;
      m_a = '0;
      m_b = '0;
      m_op = '0;
      m_res = '0;
      m_z = 1'b0;
   endtask

   // One key press; the ALU bus carries r/z only while EXEC is observed, decoys otherwise.
   task automatic press(input logic [3:0] s, input logic [2:0] o, input logic [3:0] r, input logic z, input bit rst_exec);
      logic [2:0] tr[$];
      logic [2:0] ex[$];
      int at[$];
      logic [2:0] last;
      sw = s;
      op_sw = o;
      key_n = 1'b0;
      last = state;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         rst_n = 1'b1;
         if (i == 8) key_n = 1'b1;
         if (state != last) begin
            tr.push_back(state);
            at.push_back(i);
            last = state;
         end
         bus.ALUResult = (state == 3'd3) ? r : ~r;
         bus.Zero = (state == 3'd3) ? z : ~z;
         if (state == 3'd3 && rst_exec) rst_n = 1'b0;
      end
      if (m_state == 3'd2) begin
         ex.push_back(3'd3);
         ex.push_back(rst_exec ? 3'd0 : 3'd4);
      end else
         ex.push_back(m_state == 3'd4 ? SHOW_NEXT : m_state + 3'd1);
      check("press.transitions", tr.size(), ex.size());
      for (int k = 0; k < ex.size() && k < tr.size(); k++) check("press.next_state", 32'(tr[k]), 32'(ex[k]));
      if (m_state == 3'd2 && at.size() == 2) check("exec.one_cycle", at[1] - at[0], 1);
      case (m_state)
         3'd0: m_a = s;
         3'd1: m_b = s;
         3'd2: begin
            m_op = o;
            m_res = r;
            m_z = z;
         end
         default: ;
      endcase
      if (m_state == 3'd2 && rst_exec) model_reset();
      else m_state = ex[ex.size() - 1];
      check_all("press");
      sw = 4'($urandom);
      op_sw = 3'($urandom);
      repeat (3) @(negedge clk);
      check_all("hold");
   endtask

   task automatic rand_press();
      press(4'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 1'b0);
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      key_n = 1'b0;
      sw = 4'hA;
      op_sw = 3'd7;
      bus.ALUResult = 4'h9;
      bus.Zero = 1'b1;
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      key_n = 1'b1;
      repeat (10) @(negedge clk);
      check_all("after_reset");
      for (int n = 0; n < 5; n++) begin
         key_n = 1'b0;
         repeat (3) @(negedge clk);
         key_n = 1'b1;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      check_all("glitch");
      press(4'h5, 3'd1, 4'h7, 1'b0, 1'b0);
      press(4'h3, 3'd1, 4'h7, 1'b0, 1'b0);
      press(4'h9, 3'b000, 4'h1, 1'b0, 1'b0);
      rand_press();
      for (int k = 0; k < 4 && m_state != 3'd2; k++) rand_press();
      press(4'h6, 3'd5, 4'h0, 1'b1, 1'b0);
      rand_press();
      for (int k = 0; k < 4 && m_state != 3'd2; k++) rand_press();
      press(4'h2, 3'd3, 4'hC, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) rand_press();
      rand_press();
      @(negedge clk);
      force dut.state = 3'd6;
      #1 release dut.state;
      @(negedge clk);
      m_state = 3'd0;
      check_all("illegal");
      for (int k = 0; k < 20; k++) rand_press();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Front-end stage for the ALU on the DE10-Lite board. It debounces a single pushbutton and steps a small state machine through three capture steps: operand A, operand B, then the opcode, all taken from the slide switches. It drives SrcA, SrcB and ALUControl into the ALU, registers the returned ALUResult and Zero, and holds them stable for the LEDs and 7-segment display.

Parameters:
WIDTH, 4, operand and result width; must match the ALU instance.
DEBOUNCE_CYCLES, 500000, number of consecutive equal synchronised key samples needed to accept a level change; minimum 2.

Ports:
clk  input  1  system clock (50 MHz board clock)
rst_n  input  1  synchronous active-low reset
key_n  input  1  raw pushbutton, active-low, asynchronous to clk
sw  input  WIDTH  operand switches
op_sw  input  3  opcode switches
ALUResult  input  WIDTH  combinational result from the ALU
Zero  input  1  zero flag from the ALU
SrcA  output  WIDTH  registered operand A to the ALU
SrcB  output  WIDTH  registered operand B to the ALU
ALUControl  output  3  registered opcode to the ALU
result_q  output  WIDTH  captured ALU result
zero_q  output  1  captured Zero flag
state  output  3  current FSM state, for LED display
done  output  1  high while in SHOW

Behaviour:
- Reset when rst_n is sampled low at a clk edge. Values after reset:
  - SrcA, SrcB, ALUControl, result_q, zero_q = 0; done = 0; state = LOAD_A (3'd0).
  - The debouncer's accepted level = released (1), its counter = 0, both synchroniser flops = 1.
- Reset asserted mid-operation aborts any state, including EXEC, and forces the reset values above.
- Synchroniser: key_n passes through 2 flops to give key_s.
- Debouncer:
  - Counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - If key_s equals the accepted level, cnt clears to 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1 and key_s still differs, the accepted level flips and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- press: single-cycle pulse, registered, asserted the cycle after the accepted level flips 1->0. A release generates no pulse. Holding the key produces exactly one pulse.
- FSM state encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5-7 go to LOAD_A on the next edge, with registers unchanged.
- Transitions:
  - LOAD_A: on press, SrcA <= sw, go to LOAD_B.
  - LOAD_B: on press, SrcB <= sw, go to LOAD_OP.
  - LOAD_OP: on press, ALUControl <= op_sw, go to EXEC.
  - EXEC: unconditional 1-cycle stay. It gives the ALU a full cycle with stable inputs. At the exit edge, result_q <= ALUResult and zero_q <= Zero, then go to SHOW.
  - SHOW: done = 1. On press, go to LOAD_A. SrcA, SrcB, ALUControl, result_q and zero_q all hold until overwritten.
- A press arriving while in EXEC is dropped; it is not queued.
- Latency from the LOAD_OP press to result_q valid: 2 clk edges (capture opcode, then capture result).
- Switches are sampled only on the press cycle. Switch changes at any other time have no effect.
- Outputs are plain registers with no combinational path from inputs. done is decoded from the registered state.

Optional Feature:
Macro: ALU_SEQ_KEEP_OPERANDS_EN.
- Defined: a press in SHOW goes to LOAD_OP instead of LOAD_A. SrcA and SrcB are kept, so a new opcode can be applied to the same operands with one press plus EXEC.
- Undefined: a press in SHOW goes to LOAD_A, as described in Behaviour.
- Reset behaviour is identical in both builds.

Test Plan:
All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=4.
1. Reset: rst_n=0 for 2 cycles with key_n=0 held -> all outputs 0, state=0, done=0, and no press pulse until key_n has been released and pressed again.
2. Debounce: key_n low for 3 cycles then high, repeated 5 times -> state stays 0. Key_n low for 8 cycles -> exactly one press, state goes 0->1, SrcA = sw.
3. Full op: sw=4'h5 press, sw=4'h3 press, op_sw=3'b000 press -> SrcA=5, SrcB=3, ALUControl=0; state 2->3->4 on consecutive edges. result_q equals the ALUResult driven during EXEC, e.g. 4'h1 with Zero=0 -> result_q=1, zero_q=0, done=1.
4. Zero capture: bench drives ALUResult=0, Zero=1 during EXEC -> zero_q=1. ALUResult changed to 4'hF while in SHOW -> result_q stays 0.
5. Reset mid-EXEC: rst_n=0 on the EXEC cycle -> next edge state=0, result_q=0, SrcA=SrcB=0. Press in SHOW without the macro -> state=0; with ALU_SEQ_KEEP_OPERANDS_EN -> state=2 and SrcA, SrcB unchanged.
6. Illegal state: force state=3'd6 -> next edge state=0, no register change.
